// File: rtl/bnn_threshold_pack.sv
// BNN output stage: per-channel threshold compare, LSB-first bit packing, output word FIFO.
// Optional BNN_THR_POLARITY_EN adds a per-channel polarity bank that flips the compare direction.
module bnn_threshold_pack #(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned N_CH       = 64,
   parameter int unsigned ACC_W      = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_in_valid,
   input  logic signed [ACC_W-1:0] i_in_acc,
   input  logic                    i_thr_we,
   input  logic [CH_W-1:0]         i_thr_addr,
   input  logic signed [ACC_W-1:0] i_thr_data,
`ifdef BNN_THR_POLARITY_EN
   input  logic                    i_thr_pol_data,
`endif
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [WORD_W-1:0]       o_out_word,
   output logic                    o_out_last,
   output logic                    o_overflow,
   output logic                    o_busy
);

   localparam int unsigned PW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);
   localparam logic [PW-1:0]   POS_LAST = PW'(WORD_W - 1);

   logic signed [ACC_W-1:0] r_thr [N_CH];
   logic [CH_W-1:0]         r_ch;
   logic [PW-1:0]           r_pos;
   logic [WORD_W-1:0]       r_pack;
   logic [WORD_W-1:0]       r_mem_word [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   r_mem_last;
   logic [FW:0]             r_wptr;
   logic [FW:0]             r_rptr;
   logic                    r_overflow;

   logic [CH_W-1:0]         w_ch;
   logic [PW-1:0]           w_pos;
   logic [WORD_W-1:0]       w_word;
   logic                    w_bit;
   logic                    w_done;
   logic                    w_push;
   logic                    w_wr;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_addr_ok;

   generate
      if (N_CH == 2 ** CH_W) begin : g_addr_full
         assign w_addr_ok = 1'b1;
      end else begin : g_addr_cmp
         assign w_addr_ok = (i_thr_addr < CH_W'(N_CH));
      end
   endgenerate

`ifdef BNN_THR_POLARITY_EN
   logic [N_CH-1:0] r_pol;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pol <= '0;
      end else if (i_thr_we && w_addr_ok) begin
         r_pol[i_thr_addr] <= i_thr_pol_data;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(N_CH); i++) r_thr[i] <= '0;
      end else if (i_thr_we && w_addr_ok) begin
         r_thr[i_thr_addr] <= i_thr_data;
      end
   end

   // start in the same cycle as in_valid makes the sample channel 0 of a fresh word
   always_comb begin
      w_ch   = i_start ? '0 : r_ch;
      w_pos  = i_start ? '0 : r_pos;
      w_word = i_start ? '0 : r_pack;
`ifdef BNN_THR_POLARITY_EN
      w_bit  = r_pol[w_ch] ? (i_in_acc <= r_thr[w_ch]) : (i_in_acc >= r_thr[w_ch]);
`else
      w_bit  = (i_in_acc >= r_thr[w_ch]);
`endif
      w_word[w_pos] = w_bit;
      w_done = (w_pos == POS_LAST) || (w_ch == CH_LAST);
      w_push = i_in_valid && w_done;
   end

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[FW-1:0] == r_rptr[FW-1:0]) && (r_wptr[FW] != r_rptr[FW]);
   assign w_pop   = !w_empty && i_out_ready;
   assign w_wr    = w_push && (!w_full || w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ch   <= '0;
         r_pos  <= '0;
         r_pack <= '0;
      end else if (i_in_valid) begin
         r_ch   <= (w_ch == CH_LAST) ? '0 : w_ch + 1'b1;
         r_pos  <= w_done ? '0 : w_pos + 1'b1;
         r_pack <= w_done ? '0 : w_word;
      end else if (i_start) begin
         r_ch   <= '0;
         r_pos  <= '0;
         r_pack <= '0;
      end
   end

   // a drop in the same cycle as start still flags the new vector
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end else if (i_start) begin
         r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem_word[i] <= '0;
         r_mem_last <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         if (w_wr) begin
            r_mem_word[r_wptr[FW-1:0]] <= w_word;
            r_mem_last[r_wptr[FW-1:0]] <= (w_ch == CH_LAST);
            r_wptr                     <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   assign o_out_valid = !w_empty;
   assign o_out_word  = r_mem_word[r_rptr[FW-1:0]];
   assign o_out_last  = r_mem_last[r_rptr[FW-1:0]];
   assign o_overflow  = r_overflow;
   assign o_busy      = (r_pos != '0) || !w_empty;

endmodule

// File: doc/bnn_threshold_pack.md
# bnn_threshold_pack

Binarizing output stage for the BNN datapath. Sits directly downstream of the XNOR-popcount dot unit and consumes one signed accumulator per output channel. It compares each accumulator against a per-channel threshold that encodes the folded batch-norm. The resulting sign bits are packed LSB-first into WORD_W-bit words, which are buffered in a small FIFO and offered to the next layer's activation memory through a valid/ready handshake.

## Interface
- WORD_W, 32, packed output word width (bits per word)
- N_CH, 64, output channels per vector; any value ≥ 1
- ACC_W, 32, signed accumulator and threshold width
- FIFO_DEPTH, 4, output FIFO depth in words; power of two, ≥ 2
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin new vector: clears channel counter, partial word and overflow
- in_valid  in  1  one accumulator present (driven by dot unit's done pulse)
- in_acc  in  ACC_W  signed accumulator for current channel
- thr_we  in  1  threshold write strobe
- thr_addr  in  clog2(N_CH) (min 1)  threshold index
- thr_data  in  ACC_W  signed threshold value
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_word  out  WORD_W  packed bits, channel k at bit (k mod WORD_W)
- out_last  out  1  head word is the final word of its vector
- overflow  out  1  sticky: a word was dropped because FIFO full
- busy  out  1  partial word pending or FIFO non-empty

## Operation
- Threshold bank: N_CH signed registers, reset to 0; written when thr_we, thr_addr < N_CH (out-of-range writes ignored).
- Per in_valid: bit = (in_acc ≥ thr[ch]) signed compare, full ACC_W; bit written into shift/pack register at position ch mod WORD_W; ch increments, wraps N_CH-1 → 0.
- Word complete when (ch mod WORD_W) == WORD_W-1 or ch == N_CH-1; word pushed with last = (ch == N_CH-1); unused upper bits of a final partial word are 0.
- After push, pack register cleared to 0.
- start: ch ← 0, pack register ← 0, overflow ← 0; FIFO contents retained. start with in_valid same cycle: sample taken as channel 0 of the new vector.
- thr_we and in_valid on same channel same cycle: compare uses old threshold.
- FIFO push when full and no pop same cycle: word dropped, overflow ← 1, channel counter still advances. Push while full with pop (out_valid & out_ready) same cycle: accepted.
- Pop on out_valid & out_ready; out_word/out_last hold stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid 0, out_word 0, out_last 0, overflow 0, busy 0; ch 0, FIFO empty, thresholds 0.
- in_valid completing a word at edge t → out_valid = 1 from cycle t+1 (one-cycle latency, FIFO empty).
- Throughput one accumulator per cycle; one word per cycle out.
- out_word/out_last driven from FIFO head register array; out_valid = !empty; no combinational path from out_ready to out_valid.
- Reset asserted mid-vector: all state cleared immediately, partial word discarded; next in_valid is channel 0.

## Configuration
- BNN_THR_POLARITY_EN defined: adds input thr_pol_data (1 bit, written with thr_we) and a per-channel polarity bank (reset 0); polarity 1 gives bit = (in_acc ≤ thr[ch]), covering negative batch-norm scale.
- Undefined: no thr_pol_data port, no polarity storage; always bit = (in_acc ≥ thr[ch]).

## Test plan
- Defaults, thresholds 0, start, 64 accs alternating +2,−2 from ch0, out_ready=1 → words 0x55555555 (out_last 0) then 0x55555555 (out_last 1), each out_valid one cycle after its 32nd sample.
- thr[5]=10; acc 10 at ch5 → bit5=1; repeat vector with acc 9 → bit5=0; acc −2^31 vs thr 0 → bit 0.
- N_CH=40: 40 accs all +1 → 0xFFFFFFFF then 0x000000FF with out_last=1.
- out_ready=0, FIFO_DEPTH=4, feed three 64-channel vectors → 4 words held, overflow=1 after word 5; release out_ready → exactly 4 words from vectors 1–2 in order; start → overflow=0.
- Reset asserted after 10 channels → all outputs 0 asynchronously; after release, 32 accs of +1 → 0xFFFFFFFF.
- start coincident with in_valid mid-vector (ch 17) → that sample lands at bit 0 of fresh word; thr_we to same channel same cycle → old threshold used.
